// File: rtl/clic_seq_arb_pkg.sv
// Shared types and helpers for the sequential CLIC max-level arbiter.
package clic_seq_arb_pkg;

  localparam int unsigned CLIC_ID_W  = 10;
  localparam int unsigned CLIC_LVL_W = 8;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    PRESENT = 2'd1,
    KILL    = 2'd2
  } clic_arb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [CLIC_ID_W-1:0]  id;
    logic [CLIC_LVL_W-1:0] level;
    logic                  shv;
  } clic_arb_cand_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 32'd1) / b;
  endfunction

  // Challenger beats incumbent on strictly higher level, or equal level with higher id.
  function automatic logic cand_wins(input clic_arb_cand_t chal, input clic_arb_cand_t inc);
    return chal.valid && (!inc.valid || (chal.level > inc.level) ||
                          ((chal.level == inc.level) && (chal.id > inc.id)));
  endfunction

endpackage

// File: rtl/clic_arb_group_max.sv
// Combinational max over one scan group plus the running best of the current sweep.
module clic_arb_group_max
  import clic_seq_arb_pkg::*;
#(
  parameter int unsigned GROUP = 4
) (
  input  clic_arb_cand_t [GROUP-1:0] grp_i,
  input  clic_arb_cand_t             best_i,
  output clic_arb_cand_t             best_o
);

  // Entries are visited in ascending id order so ties settle on the highest id.
  always_comb begin
    best_o = best_i;
    for (int unsigned g = 0; g < GROUP; g++) begin
      best_o = cand_wins(grp_i[g], best_o) ? grp_i[g] : best_o;
    end
  end

endmodule

// File: rtl/clic_seq_arb.sv
// Multi-cycle max-level interrupt arbiter: sweeps GROUP sources per cycle and
// presents the sweep winner to the hart over valid/ready with a kill handshake.
module clic_seq_arb
  import clic_seq_arb_pkg::*;
#(
  parameter  int unsigned N_SOURCE   = 32,
  parameter  int unsigned INTCTLBITS = 8,
  parameter  int unsigned GROUP      = 4,
  localparam int unsigned SRC_W      = $clog2(N_SOURCE)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_SOURCE-1:0]          ip_i,
  input  logic [N_SOURCE-1:0]          ie_i,
  input  logic [N_SOURCE-1:0]          le_i,
  input  logic [N_SOURCE-1:0]          shv_i,
  input  logic [N_SOURCE-1:0][7:0]     intctl_i,
  input  logic [7:0]                   thresh_i,
  output logic                         irq_valid_o,
  input  logic                         irq_ready_i,
  output logic [SRC_W-1:0]             irq_id_o,
  output logic [7:0]                   irq_level_o,
  output logic                         irq_shv_o,
  output logic                         irq_kill_req_o,
  input  logic                         irq_kill_ack_i,
  output logic [N_SOURCE-1:0]          clear_o
);

  localparam int unsigned NGRP  = ceil_div(N_SOURCE, GROUP);
  localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [7:0]  UNIMPL_MASK = 8'((32'd1 << (32'd8 - INTCTLBITS)) - 32'd1);

  clic_arb_state_e             state_q;
  logic [GRP_W-1:0]            grp_q;
  clic_arb_cand_t              best_q;
  logic                        valid_q, kill_q, shv_q;
  logic [SRC_W-1:0]            id_q;
  logic [7:0]                  level_q;
  logic [N_SOURCE-1:0]         clear_q;

  clic_arb_cand_t [GROUP-1:0]  grp_cand_s;
  clic_arb_cand_t              merged_s;
  logic [SRC_W-1:0]            sid_s;
  int unsigned                 base_s;
  logic                        sweep_end_s, accept_s, pres_cand_s, preempt_s;

  assign base_s      = 32'(grp_q) * GROUP;
  assign sweep_end_s = (grp_q == GRP_W'(NGRP - 1));
  assign accept_s    = (state_q != SCAN) && irq_ready_i;
  assign pres_cand_s = ip_i[id_q] && ie_i[id_q] && ((intctl_i[id_q] | UNIMPL_MASK) > thresh_i);
  assign preempt_s   = (merged_s.valid && (merged_s.level > level_q)) || !pres_cand_s;

  // Candidate view of the group under scan; ids past N_SOURCE never qualify.
  always_comb begin
    grp_cand_s = '0;
    sid_s      = '0;
    for (int unsigned g = 0; g < GROUP; g++) begin
      if ((base_s + g) < N_SOURCE) begin
        sid_s               = SRC_W'(base_s + g);
        grp_cand_s[g].valid = ip_i[sid_s] && ie_i[sid_s] &&
                              ((intctl_i[sid_s] | UNIMPL_MASK) > thresh_i);
        grp_cand_s[g].id    = CLIC_ID_W'(sid_s);
        grp_cand_s[g].level = intctl_i[sid_s] | UNIMPL_MASK;
        grp_cand_s[g].shv   = shv_i[sid_s];
      end else begin
        grp_cand_s[g] = '0;
      end
    end
  end

  clic_arb_group_max #(.GROUP(GROUP)) u_group_max (
    .grp_i  (grp_cand_s),
    .best_i (best_q),
    .best_o (merged_s)
  );

  // Sweep counter, running best and the presentation FSM with its output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SCAN;
      grp_q   <= '0;
      best_q  <= '0;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      id_q    <= '0;
      level_q <= 8'd0;
      shv_q   <= 1'b0;
      clear_q <= '0;
    end else begin
      clear_q <= '0;
      if (accept_s || sweep_end_s) begin
        grp_q  <= '0;
        best_q <= '0;
      end else begin
        grp_q  <= grp_q + 1'b1;
        best_q <= merged_s;
      end
      case (state_q)
        SCAN: begin
          if (sweep_end_s && merged_s.valid) begin
            state_q <= PRESENT;
            valid_q <= 1'b1;
            id_q    <= merged_s.id[SRC_W-1:0];
            level_q <= merged_s.level;
            shv_q   <= merged_s.shv;
          end
        end
        PRESENT: begin
          if (irq_ready_i) begin
            state_q       <= SCAN;
            valid_q       <= 1'b0;
            clear_q[id_q] <= le_i[id_q];
          end else if (sweep_end_s && preempt_s) begin
            state_q <= KILL;
            kill_q  <= 1'b1;
          end
        end
        KILL: begin
          if (irq_ready_i) begin
            state_q       <= SCAN;
            valid_q       <= 1'b0;
            kill_q        <= 1'b0;
            clear_q[id_q] <= le_i[id_q];
          end else if (irq_kill_ack_i) begin
            state_q <= SCAN;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= SCAN;
          valid_q <= 1'b0;
          kill_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_valid_o    = valid_q;
  assign irq_kill_req_o = kill_q;
  assign irq_id_o       = id_q;
  assign irq_level_o    = level_q;
  assign irq_shv_o      = shv_q;
  assign clear_o        = clear_q;

endmodule

// File: tb/tb_clic_seq_arb.sv
// Bench for clic_seq_arb: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a sweep-level reference model.
module tb_clic_seq_arb;

  localparam int N  = 32;
  localparam int G  = 4;
  localparam int NG = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      ip, ie, le, shv;
  logic [31:0][7:0] intctl;
  logic [7:0]       thresh;
  logic             ready, ack;
  logic             valid, kill, shv_o;
  logic [4:0]       id;
  logic [7:0]       level;
  logic [31:0]      clear;

  logic [29:0]      ip2, ie2, le2, shv2;
  logic [29:0][7:0] intctl2;
  logic             ready2, ack2;
  logic             valid2, kill2, shv2_o;
  logic [4:0]       id2;
  logic [7:0]       level2;
  logic [29:0]      clear2;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic        m_valid, m_kill, m_shv;
  logic [4:0]  m_id;
  logic [7:0]  m_level;
  logic [31:0] m_clear;
  int          pos;
  logic        bv, bshv;
  logic [4:0]  bid;
  logic [7:0]  bl;

  clic_seq_arb #(.N_SOURCE(32), .INTCTLBITS(8), .GROUP(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ip_i(ip), .ie_i(ie), .le_i(le), .shv_i(shv),
    .intctl_i(intctl), .thresh_i(thresh), .irq_valid_o(valid), .irq_ready_i(ready),
    .irq_id_o(id), .irq_level_o(level), .irq_shv_o(shv_o), .irq_kill_req_o(kill),
    .irq_kill_ack_i(ack), .clear_o(clear)
  );

  clic_seq_arb #(.N_SOURCE(30), .INTCTLBITS(8), .GROUP(4)) dut30 (
    .clk_i(clk), .rst_ni(rst_n), .ip_i(ip2), .ie_i(ie2), .le_i(le2), .shv_i(shv2),
    .intctl_i(intctl2), .thresh_i(thresh), .irq_valid_o(valid2), .irq_ready_i(ready2),
    .irq_id_o(id2), .irq_level_o(level2), .irq_shv_o(shv2_o), .irq_kill_req_o(kill2),
    .irq_kill_ack_i(ack2), .clear_o(clear2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_cand(input logic [4:0] i);
    return ip[i] && ie[i] && (intctl[i] > thresh);
  endfunction

  // One clock of the reference: merge the group at 'pos', then apply the handshake rules.
  task automatic model_step();
    logic       rv, rs, send, pc;
    logic [4:0] rid;
    logic [7:0] rl;
    rv = bv; rid = bid; rl = bl; rs = bshv;
    for (int g = 0; g < G; g++) begin
      logic [4:0] i;
      i = 5'(pos * G + g);
      if (is_cand(i) && (!rv || intctl[i] > rl || (intctl[i] == rl && i > rid))) begin
        rv = 1'b1; rid = i; rl = intctl[i]; rs = shv[i];
      end
    end
    send    = (pos == NG - 1);
    pc      = is_cand(m_id);
    m_clear = 32'd0;
    if (m_valid && ready) begin
      if (le[m_id]) m_clear[m_id] = 1'b1;
      m_valid = 1'b0; m_kill = 1'b0; pos = 0; bv = 1'b0;
    end else begin
      if (m_kill && ack) begin
        m_valid = 1'b0; m_kill = 1'b0;
      end else if (!m_valid && send && rv) begin
        m_valid = 1'b1; m_id = rid; m_level = rl; m_shv = rs;
      end else if (m_valid && !m_kill && send && ((rv && rl > m_level) || !pc)) begin
        m_kill = 1'b1;
      end
      if (send) begin
        pos = 0; bv = 1'b0;
      end else begin
        pos = pos + 1; bv = rv; bid = rid; bl = rl; bshv = rs;
      end
    end
  endtask

  // Reference model clocking with asynchronous reset.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 1'b0; m_kill = 1'b0; m_shv = 1'b0; m_id = 5'd0; m_level = 8'd0;
        m_clear = 32'd0; pos = 0; bv = 1'b0; bid = 5'd0; bl = 8'd0; bshv = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison of the 32-source DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_valid", 32'(valid), 32'(m_valid));
        chk("cyc_kill",  32'(kill),  32'(m_kill));
        chk("cyc_id",    32'(id),    32'(m_id));
        chk("cyc_level", 32'(level), 32'(m_level));
        chk("cyc_shv",   32'(shv_o), 32'(m_shv));
        chk("cyc_clear", clear,      m_clear);
      end
    end
  end

  // sel: 0 = valid, 1 = kill_req, 2 = valid of the 30-source build
  task automatic wait_for(input string nm, input int sel, input int maxc);
    int   n;
    logic s;
    n = 0;
    s = 1'b0;
    while (!s && n < maxc) begin
      @(negedge clk);
      n++;
      s = (sel == 0) ? valid : (sel == 1) ? kill : valid2;
    end
    tests++;
    if (!s) begin
      fails++;
      $display("FAIL %s: got 0 after %0d cycles, required 1", nm, maxc);
    end
  endtask

  task automatic quiesce();
    ip = 32'd0; ie = 32'd0; le = 32'd0; shv = 32'd0; ready = 1'b0; ack = 1'b0;
    repeat (NG + 2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] s;
    bit         seen;
    rst_n = 1'b0; ip = 32'd0; ie = 32'd0; le = 32'd0; shv = 32'd0; intctl = '0;
    thresh = 8'd0; ready = 1'b0; ack = 1'b0;
    ip2 = 30'd0; ie2 = 30'd0; le2 = 30'd0; shv2 = 30'd0; intctl2 = '0;
    ready2 = 1'b0; ack2 = 1'b0;
    ip[5] = 1'b1; ie[5] = 1'b1; intctl[5] = 8'h40;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_kill",  32'(kill),  32'd0);
    chk("rst_id",    32'(id),    32'd0);
    chk("rst_clear", clear,      32'd0);
    rst_n = 1'b1;

    // 1: single source from reset
    wait_for("t1_valid", 0, 9);
    chk("t1_id", 32'(id), 32'd5);
    chk("t1_level", 32'(level), 32'h40);
    ready = 1'b1; ip = 32'd0;
    @(negedge clk);
    ready = 1'b0;
    chk("t1_drop", 32'(valid), 32'd0);
    chk("t1_noclear", clear, 32'd0);
    quiesce();

    // 2: tie on level resolves to higher id; edge clear pulses once
    ip[3] = 1'b1; ie[3] = 1'b1; le[3] = 1'b1; intctl[3] = 8'h80;
    ip[30] = 1'b1; ie[30] = 1'b1; le[30] = 1'b1; intctl[30] = 8'h80;
    wait_for("t2_valid", 0, 2 * NG + 1);
    chk("t2_id", 32'(id), 32'd30);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0; ip = 32'd0;
    chk("t2_clear", clear, 32'h4000_0000);
    @(negedge clk);
    chk("t2_clear_once", clear, 32'd0);
    quiesce();

    // 3: preemption by a higher source, kill acknowledged, then the new winner
    ip[7] = 1'b1; ie[7] = 1'b1; intctl[7] = 8'h20;
    wait_for("t3_valid7", 0, 2 * NG + 1);
    chk("t3_id7", 32'(id), 32'd7);
    ip[12] = 1'b1; ie[12] = 1'b1; intctl[12] = 8'h90;
    wait_for("t3_kill", 1, 2 * NG + 1);
    chk("t3_kill_id", 32'(id), 32'd7);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t3_ack_valid", 32'(valid), 32'd0);
    chk("t3_ack_kill", 32'(kill), 32'd0);
    wait_for("t3_valid12", 0, 2 * NG + 1);
    chk("t3_id12", 32'(id), 32'd12);
    chk("t3_level12", 32'(level), 32'h90);
    ready = 1'b1; ip = 32'd0;
    @(negedge clk);
    ready = 1'b0;
    quiesce();

    // 4: ready and ack together in KILL count as an accept
    ip[7] = 1'b1; ie[7] = 1'b1; le[7] = 1'b1; intctl[7] = 8'h20;
    wait_for("t4_valid", 0, 2 * NG + 1);
    ip[12] = 1'b1; ie[12] = 1'b1; intctl[12] = 8'h90;
    wait_for("t4_kill", 1, 2 * NG + 1);
    ready = 1'b1; ack = 1'b1;
    @(negedge clk);
    ready = 1'b0; ack = 1'b0; ip = 32'd0;
    chk("t4_valid", 32'(valid), 32'd0);
    chk("t4_kill", 32'(kill), 32'd0);
    chk("t4_id", 32'(id), 32'd7);
    chk("t4_clear", clear, 32'h0000_0080);
    quiesce();

    // 5: threshold is a strict compare
    thresh = 8'h50;
    ip[9] = 1'b1; ie[9] = 1'b1; intctl[9] = 8'h50;
    seen = 1'b0;
    repeat (2 * NG + 2) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    chk("t5_never", 32'(seen), 32'd0);
    thresh = 8'h4F;
    wait_for("t5_valid", 0, 2 * NG + 1);
    chk("t5_id", 32'(id), 32'd9);
    ready = 1'b1; ip = 32'd0;
    @(negedge clk);
    ready = 1'b0; thresh = 8'd0;
    quiesce();

    // 6: non-multiple source count, then reset while presenting
    ip2[29] = 1'b1; ie2[29] = 1'b1; le2[29] = 1'b1; intctl2[29] = 8'h33;
    wait_for("t6_valid", 2, 2 * NG + 1);
    chk("t6_id", 32'(id2), 32'd29);
    chk("t6_level", 32'(level2), 32'h33);
    ready2 = 1'b1; rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(valid2), 32'd0);
    chk("t6_rst_id", 32'(id2), 32'd0);
    chk("t6_rst_level", 32'(level2), 32'd0);
    chk("t6_rst_clear", 32'(clear2), 32'd0);
    @(negedge clk);
    chk("t6_rst_clear2", 32'(clear2), 32'd0);
    ready2 = 1'b0; ip2 = 30'd0;
    rst_n = 1'b1;

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ready = ($urandom_range(0, 7) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        s = 5'($urandom_range(0, 31));
        ip[s]     = $urandom_range(0, 2) != 0;
        ie[s]     = $urandom_range(0, 3) != 0;
        le[s]     = $urandom_range(0, 1) != 0;
        shv[s]    = $urandom_range(0, 1) != 0;
        intctl[s] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 7) << 5);
      end
      if ($urandom_range(0, 149) == 0) thresh = 8'($urandom_range(0, 96));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
